// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle LEGv8 core.
// Walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK against a
// variable-latency memory, counts retired instructions and stops on halt or bus error.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [10:0]         opcode,
    input  logic                branch_taken,
    input  logic                mem_ready,
    input  logic                halt_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                alu_src_imm,
    output logic [1:0]          imm_sel,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                illegal,
    output logic                bus_error,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired
);

    localparam int            TW       = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    // Opcode fields (instruction[31:21]); narrower formats compare only their top bits.
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_EOR   = 11'b11001010000;
    localparam logic [10:0] OP_LSL   = 11'b11010011011;
    localparam logic [10:0] OP_LSR   = 11'b11010011010;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
    localparam logic [9:0]  OP_EORI  = 10'b1101001000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B     = 6'b000101;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_IMM, C_LD, C_ST, C_CB, C_B, C_ILL
    } cls_t;

    state_t              state_q, state_d;
    cls_t                cls_q, cls_d, dec_cls;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                bus_error_q, bus_error_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                tmo_hit, retire, skip;

    assign bus_error = bus_error_q;
    assign retired   = retired_q;

    // Immediate format used by the sign extender for a given class.
    function automatic logic [1:0] imm_fmt(cls_t c);
        case (c)
            C_LD, C_ST: imm_fmt = 2'd1;
            C_CB:       imm_fmt = 2'd2;
            C_B:        imm_fmt = 2'd3;
            default:    imm_fmt = 2'd0;
        endcase
    endfunction

    // Classify the opcode currently held in the IR.
    always_comb begin
        dec_cls = C_ILL;
        if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR ||
            opcode == OP_EOR || opcode == OP_LSL || opcode == OP_LSR)
            dec_cls = C_R;
        else if (opcode[10:1] == OP_ADDI || opcode[10:1] == OP_SUBI || opcode[10:1] == OP_ANDI ||
                 opcode[10:1] == OP_ORRI || opcode[10:1] == OP_EORI)
            dec_cls = C_IMM;
        else if (opcode == OP_LDUR)
            dec_cls = C_LD;
        else if (opcode == OP_STUR)
            dec_cls = C_ST;
        else if (opcode[10:3] == OP_CBZ || opcode[10:3] == OP_CBNZ || opcode[10:3] == OP_BCOND)
            dec_cls = C_CB;
        else if (opcode[10:5] == OP_B)
            dec_cls = C_B;
    end

    // Next-state, counters and all strobes from state, class and handshake inputs.
    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        tmo_d       = tmo_q;
        bus_error_d = bus_error_q;
        retired_d   = retired_q;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_src_imm = 1'b0;
        imm_sel     = 2'd0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;
        retire      = 1'b0;
        skip        = 1'b0;
        tmo_hit     = !mem_ready && (tmo_q == TMO_LAST);

        case (state_q)
            S_FETCH: begin
                if (tmo_hit) begin
                    // Request is dropped in the timeout cycle itself.
                    bus_error_d = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        state_d  = S_DECODE;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            S_DECODE: begin
                cls_d   = dec_cls;
                imm_sel = imm_fmt(dec_cls);
                if (dec_cls == C_ILL) begin
                    illegal  = 1'b1;
                    pc_write = 1'b1;
                    skip     = 1'b1;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                imm_sel     = imm_fmt(cls_q);
                alu_src_imm = (cls_q == C_IMM) || (cls_q == C_LD) || (cls_q == C_ST);
                case (cls_q)
                    C_LD, C_ST: begin
                        state_d = S_MEMORY;
                        tmo_d   = '0;
                    end
                    C_CB: begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken;
                        retire   = 1'b1;
                    end
                    C_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                    end
                    default: state_d = S_WRITEBACK;
                endcase
            end
            S_MEMORY: begin
                iord    = 1'b1;
                imm_sel = imm_fmt(cls_q);
                if (tmo_hit) begin
                    bus_error_d = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    mem_read  = (cls_q == C_LD);
                    mem_write = (cls_q != C_LD);
                    if (mem_ready) begin
                        if (cls_q == C_LD) begin
                            state_d = S_WRITEBACK;
                        end else begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            S_WRITEBACK: begin
                imm_sel    = imm_fmt(cls_q);
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LD);
                pc_write   = 1'b1;
                retire     = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
                if (!bus_error_q && !halt_req) begin
                    state_d = S_FETCH;
                    tmo_d   = '0;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Instruction boundary: halt_req is only honoured here.
        if (retire || skip) begin
            state_d = halt_req ? S_HALT : S_FETCH;
            tmo_d   = '0;
        end
        if (retire)
            retired_d = retired_q + RETIRE_W'(1);

        // Nothing leaves the controller during the reset cycle.
        if (reset) begin
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 1'b0;
            iord        = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            alu_src_imm = 1'b0;
            imm_sel     = 2'd0;
            reg_write   = 1'b0;
            mem_to_reg  = 1'b0;
            illegal     = 1'b0;
            halted      = 1'b0;
        end
    end

    // State, class, timeout, sticky bus error and retire count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            cls_q       <= C_R;
            tmo_q       <= '0;
            bus_error_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            tmo_q       <= tmo_d;
            bus_error_q <= bus_error_d;
            retired_q   <= retired_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed + randomized bench for multicycle_controller. Each instruction is expanded
// into its expected cycle-by-cycle strobe list from the class rules, then replayed.
module tb_multicycle_controller;

    localparam int R = 0, IMM = 1, LD = 2, ST = 3, CB = 4, BR = 5, ILL = 6;

    logic        clk = 1'b0;
    logic        reset, branch_taken, mem_ready, halt_req;
    logic [10:0] opcode;
    logic        ir_write, pc_write, pc_src, iord, mem_read, mem_write, alu_src_imm;
    logic [1:0]  imm_sel;
    logic        reg_write, mem_to_reg, illegal, bus_error, halted;
    logic [31:0] retired;

    typedef struct packed {
        logic       ir_write, pc_write, pc_src, iord, mem_read, mem_write, alu_src_imm;
        logic [1:0] imm_sel;
        logic       reg_write, mem_to_reg, illegal, halted;
    } exp_t;

    typedef struct {
        logic        rst;
        logic [10:0] op;
        logic        rdy, bt, hr;
        exp_t        e;
        logic [31:0] ret;
        logic        berr;
        bit          chk;
        string       tag;
    } cyc_t;

    cyc_t        q[$];
    logic [10:0] cur_op;
    logic [31:0] m_ret;
    logic        m_berr;
    int          n_chk, n_pass, n_fail, cyc;

    multicycle_controller #(.MEM_TIMEOUT(16), .RETIRE_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .halt_req(halt_req), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .alu_src_imm(alu_src_imm), .imm_sel(imm_sel),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .bus_error(bus_error), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        rb = 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] fmt(int cls);
        case (cls)
            IMM:     fmt = 2'd0;
            LD, ST:  fmt = 2'd1;
            CB:      fmt = 2'd2;
            BR:      fmt = 2'd3;
            default: fmt = 2'd0;
        endcase
    endfunction

    function automatic logic [10:0] pick_op(int cls);
        logic [10:0] o;
        o = 11'h000;
        case (cls)
            R: case ($urandom_range(0, 6))
                0: o = 11'h458; 1: o = 11'h658; 2: o = 11'h450; 3: o = 11'h550;
                4: o = 11'h650; 5: o = 11'h69B; default: o = 11'h69A;
            endcase
            IMM: begin
                case ($urandom_range(0, 4))
                    0: o = 11'h488; 1: o = 11'h688; 2: o = 11'h490; 3: o = 11'h590;
                    default: o = 11'h690;
                endcase
                o = o | 11'($urandom_range(0, 1));
            end
            LD: o = 11'h7C2;
            ST: o = 11'h7C0;
            CB: begin
                case ($urandom_range(0, 2))
                    0: o = 11'h5A0; 1: o = 11'h5A8; default: o = 11'h2A0;
                endcase
                o = o + 11'($urandom_range(0, 7));
            end
            BR: o = 11'h0A0 + 11'($urandom_range(0, 31));
            default: case ($urandom_range(0, 3))
                0: o = 11'h000; 1: o = 11'h7FF; 2: o = 11'h7C1; default: o = 11'h459;
            endcase
        endcase
        pick_op = o;
    endfunction

    task automatic push(string tag, logic rdy, logic bt, logic hr, exp_t e, bit ret_inc);
        cyc_t c;
        c.rst = 1'b0; c.op = cur_op; c.rdy = rdy; c.bt = bt; c.hr = hr; c.e = e;
        c.ret = m_ret; c.berr = m_berr; c.chk = 1'b1; c.tag = tag;
        q.push_back(c);
        if (ret_inc) m_ret = m_ret + 32'd1;
    endtask

    task automatic push_reset();
        cyc_t c;
        c.rst = 1'b1; c.op = cur_op; c.rdy = rb(); c.bt = rb(); c.hr = 1'b0; c.e = '0;
        c.ret = '0; c.berr = 1'b0; c.chk = 1'b0; c.tag = "reset";
        q.push_back(c);
        m_ret = '0; m_berr = 1'b0;
    endtask

    task automatic halt_tail(bit hr, int hk);
        exp_t e;
        e = '0; e.halted = 1'b1;
        if (hr) begin
            for (int i = 0; i < hk; i++) push("halt_hold", rb(), rb(), 1'b1, e, 0);
            push("halt_exit", rb(), rb(), 1'b0, e, 0);
        end
    endtask

    // Expected cycle list for one instruction of class cls.
    task automatic gen(int cls, int op_in, int fw, int mw, bit bt, bit hr, int hk);
        exp_t       e;
        logic [1:0] f;
        cur_op = (op_in >= 0) ? 11'(op_in) : pick_op(cls);
        f = fmt(cls);
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_read = 1'b1;
            push("fetch_wait", 1'b0, rb(), hr, e, 0);
        end
        e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
        push("fetch", 1'b1, rb(), hr, e, 0);
        e = '0; e.imm_sel = f;
        if (cls == ILL) begin
            e.illegal = 1'b1; e.pc_write = 1'b1;
            push("decode_ill", rb(), rb(), hr, e, 0);
            halt_tail(hr, hk);
            return;
        end
        push("decode", rb(), rb(), hr, e, 0);
        e = '0; e.imm_sel = f; e.alu_src_imm = (cls == IMM || cls == LD || cls == ST);
        if (cls == CB) begin
            e.pc_write = 1'b1; e.pc_src = bt;
            push("exec_cb", rb(), bt, hr, e, 1);
            halt_tail(hr, hk);
            return;
        end
        if (cls == BR) begin
            e.pc_write = 1'b1; e.pc_src = 1'b1;
            push("exec_b", rb(), rb(), hr, e, 1);
            halt_tail(hr, hk);
            return;
        end
        push("exec", rb(), rb(), hr, e, 0);
        if (cls == LD || cls == ST) begin
            for (int i = 0; i < mw; i++) begin
                e = '0; e.imm_sel = f; e.iord = 1'b1;
                e.mem_read = (cls == LD); e.mem_write = (cls == ST);
                push("mem_wait", 1'b0, rb(), hr, e, 0);
            end
            e = '0; e.imm_sel = f; e.iord = 1'b1;
            e.mem_read = (cls == LD); e.mem_write = (cls == ST); e.pc_write = (cls == ST);
            push("mem", 1'b1, rb(), hr, e, cls == ST);
            if (cls == ST) begin
                halt_tail(hr, hk);
                return;
            end
        end
        e = '0; e.imm_sel = f; e.reg_write = 1'b1; e.mem_to_reg = (cls == LD); e.pc_write = 1'b1;
        push("wb", rb(), rb(), hr, e, 1);
        halt_tail(hr, hk);
    endtask

    // Replay the queued cycles: drive after the rising edge, check on the falling edge.
    task automatic run();
        cyc_t c;
        exp_t obs;
        while (q.size() > 0) begin
            c = q.pop_front();
            reset = c.rst; opcode = c.op; mem_ready = c.rdy;
            branch_taken = c.bt; halt_req = c.hr;
            @(negedge clk);
            obs = {ir_write, pc_write, pc_src, iord, mem_read, mem_write, alu_src_imm,
                   imm_sel, reg_write, mem_to_reg, illegal, halted};
            n_chk++;
            assert (obs === c.e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s cyc=%0d strobes observed=%h expected=%h", c.tag, cyc, obs, c.e);
            end
            if (c.chk) begin
                n_chk++;
                assert (retired === c.ret) n_pass++;
                else begin
                    n_fail++;
                    $error("FAIL %s_retired cyc=%0d observed=%0d expected=%0d", c.tag, cyc, retired, c.ret);
                end
                n_chk++;
                assert (bus_error === c.berr) n_pass++;
                else begin
                    n_fail++;
                    $error("FAIL %s_bus_error cyc=%0d observed=%b expected=%b", c.tag, cyc, bus_error, c.berr);
                end
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        exp_t e;
        n_chk = 0; n_pass = 0; n_fail = 0; cyc = 0;
        m_ret = '0; m_berr = 1'b0; cur_op = 11'h000;
        reset = 1'b1; opcode = '0; mem_ready = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
        @(posedge clk);
        #1;

        // Reset: all strobes low.
        push_reset(); push_reset(); run();

        // ADDI, zero-wait memory: F D E W.
        gen(IMM, 11'h488, 0, 0, 1'b0, 1'b0, 0); run();
        // LDUR with three wait cycles in MEMORY.
        gen(LD, -1, 0, 3, 1'b0, 1'b0, 0); run();
        // CBZ taken, CBNZ not taken.
        gen(CB, 11'h5A3, 0, 0, 1'b1, 1'b0, 0); run();
        gen(CB, 11'h5AC, 0, 0, 1'b0, 1'b0, 0); run();
        // Unconditional branch.
        gen(BR, -1, 1, 0, 1'b0, 1'b0, 0); run();
        // Illegal opcode 0: skip without retiring.
        gen(ILL, 11'h000, 0, 0, 1'b0, 1'b0, 0); run();
        // STUR with halt_req raised: completes, halts, resumes.
        gen(ST, -1, 0, 1, 1'b0, 1'b1, 2); run();

        // Randomized instruction mix.
        for (int n = 0; n < 40; n++) begin
            gen($urandom_range(0, 6), -1, $urandom_range(0, 4), $urandom_range(0, 4),
                rb(), ($urandom_range(0, 5) == 0), $urandom_range(0, 2));
            run();
        end

        // Reset in the middle of a fetch drops the request.
        cur_op = pick_op(R);
        e = '0; e.mem_read = 1'b1;
        push("fetch_wait", 1'b0, rb(), 1'b0, e, 0);
        push("fetch_wait", 1'b0, rb(), 1'b0, e, 0);
        push_reset();
        gen(R, -1, 1, 0, 1'b0, 1'b0, 0); run();

        // Fetch timeout: bus error, sticky halt regardless of halt_req, cleared by reset.
        for (int i = 0; i < 15; i++) begin
            e = '0; e.mem_read = 1'b1;
            push("tmo_wait", 1'b0, rb(), 1'b0, e, 0);
        end
        e = '0;
        push("tmo_hit", 1'b0, rb(), 1'b0, e, 0);
        m_berr = 1'b1;
        e = '0; e.halted = 1'b1;
        for (int i = 0; i < 6; i++) push("tmo_halt", rb(), rb(), 1'(i % 2), e, 0);
        push_reset();
        gen(BR, -1, 0, 0, 1'b0, 1'b0, 0); run();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
